music_sequencer: RTL
====================

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter IDX_W, default 7: song index width; 2^IDX_W note entries, memory address width IDX_W+1.
REQ-002 Parameter DUR_W, default 8: duration field width in ticks.
REQ-003 Port clock, input, 1: single clock; every flop is on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle play command; honoured only in IDLE.
REQ-006 Port stop, input, 1: abort command; honoured in any state.
REQ-007 Port pause, input, 1: level; freezes playback while high.
REQ-008 Port loop_en, input, 1: replay from index 0 at the end marker.
REQ-009 Port tick_cycles, input, 24: clock cycles per duration tick; sampled on the IDLE->FETCH_NOTE transition.
REQ-010 Port mem_req, output, 1: song-memory read request.
REQ-011 Port mem_addr, output, IDX_W+1: read address; {idx,0} selects the note byte and {idx,1} the duration byte.
REQ-012 Port mem_rdata, input, 8: read data; valid only when mem_valid is high.
REQ-013 Port mem_valid, input, 1: read-complete strobe; latency is variable, minimum 1 cycle after mem_req rises.
REQ-014 Port note, output, 8: note code driven to the wavegen; 0 means silence.
REQ-015 Port playing, output, 1: high in FETCH_NOTE, FETCH_DUR and PLAY.
REQ-016 Port note_idx, output, IDX_W: index of the current entry.
REQ-017 Port song_done, output, 1: one-cycle pulse when a non-looping song ends.

Function
REQ-018 States SHALL be IDLE, FETCH_NOTE, FETCH_DUR and PLAY, and all outputs SHALL be registered.
REQ-019 In IDLE, start SHALL clear idx, latch tick_cycles (a value of 0 is treated as 1), and move to FETCH_NOTE.
REQ-020 In FETCH_NOTE, mem_req=1 and mem_addr={idx,0} SHALL be held stable until the cycle in which mem_valid=1; mem_rdata is captured in that cycle.
REQ-021 A captured note of 0xFF SHALL act as the end marker: with loop_en=1, idx<=0 and the state stays FETCH_NOTE; with loop_en=0, song_done pulses, note<=0, and the state moves to IDLE.
REQ-022 Any other note value SHALL move the state to FETCH_DUR, which uses mem_addr={idx,1} under the same handshake as FETCH_NOTE.
REQ-023 When the duration is captured, the state SHALL move to PLAY; note is updated to the fetched note, the tick counter and the cycle counter are cleared, and a duration of 0 is treated as 1.
REQ-024 During FETCH_NOTE and FETCH_DUR, note SHALL hold its previous value, with no silence glitch between entries.
REQ-025 mem_req SHALL be 0 in IDLE and PLAY, and mem_valid SHALL be ignored whenever mem_req=0.
REQ-026 In PLAY with pause=0, the cycle counter SHALL increment each cycle; on reaching latched tick_cycles-1 it returns to 0 and the tick counter increments.
REQ-027 On the tick that brings the tick counter to the duration, idx SHALL increment and the state SHALL move to FETCH_NOTE; a note therefore lasts exactly duration*tick_cycles cycles in PLAY.
REQ-028 idx SHALL wrap from 2^IDX_W-1 to 0 without any end-of-song action.
REQ-029 While pause=1 in PLAY, both counters SHALL freeze and note SHALL read 0; on pause release the stored note returns and counting resumes from the frozen values.
REQ-030 While pause=1 in a FETCH state, the fetch SHALL complete normally and pause takes effect on entry to PLAY.
REQ-031 When stop=1, the next state SHALL be IDLE with note=0 and mem_req=0, and an outstanding read is abandoned.
REQ-032 stop SHALL take priority over start and over a same-cycle mem_valid or tick event.
REQ-033 start SHALL be ignored outside IDLE, and a change to tick_cycles during playback SHALL have no effect.

Reset
REQ-034 While reset=1, the block SHALL asynchronously force state=IDLE, note=0, playing=0, mem_req=0, mem_addr=0, note_idx=0, song_done=0, both counters to 0, and the latched tick_cycles to 1.
REQ-035 When reset deasserts mid-song, playback SHALL not resume; the block waits in IDLE for start.

Verification
REQ-036 Basic play: memory {10,2,20,1,FF}, tick_cycles=4, mem latency 1, pulse start -> note=10 for 8 PLAY cycles, then note=20 for 4 PLAY cycles, song_done pulses once, note=0, playing=0.
REQ-037 Loop: same memory, loop_en=1 -> after note 20 the sequence returns to idx 0 and note=10, song_done stays 0, mem_addr sequence 0,1,2,3,4,0,1.
REQ-038 Variable latency: mem_valid delayed 5 cycles on each read -> mem_req and mem_addr stay stable throughout, and note durations in PLAY are unchanged.
REQ-039 Pause: assert pause for 10 cycles midway through note 10 -> note=0 during the pause, and total PLAY time for note 10 is still 8 unpaused cycles.
REQ-040 Stop priority: stop and mem_valid in the same cycle during FETCH_DUR -> IDLE next cycle, note=0, and a start in that same cycle is ignored.
REQ-041 Async reset: assert reset between clock edges during PLAY -> all outputs reach their REQ-034 values immediately, before the next clock edge.

Source files
------------

// File: rtl/music_sequencer.sv
// Song sequencer: fetches note/duration byte pairs from song memory and plays each note
// for duration * tick_cycles clock cycles, with pause, stop, looping and end-marker handling.
module music_sequencer #(
  parameter int unsigned IDX_W = 7,
  parameter int unsigned DUR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop_en,
  input  logic [23:0]      tick_cycles,
  output logic             mem_req,
  output logic [IDX_W:0]   mem_addr,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_valid,
  output logic [7:0]       note,
  output logic             playing,
  output logic [IDX_W-1:0] note_idx,
  output logic             song_done
);

  typedef enum logic [1:0] {StIdle, StFetchNote, StFetchDur, StPlay} state_t;

  state_t           state;
  logic [7:0]       play_note;
  logic [DUR_W-1:0] dur;
  logic [DUR_W-1:0] tick_cnt;
  logic [23:0]      cyc_cnt;
  logic [23:0]      tick_len;

  logic             rd_done;
  logic [IDX_W-1:0] idx_next;
  logic [DUR_W-1:0] rd_dur;

  // mem_valid only counts while a request is actually outstanding
  assign rd_done  = mem_req & mem_valid;
  assign idx_next = note_idx + 1'b1;
  assign rd_dur   = DUR_W'(mem_rdata);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      note      <= 8'h00;
      playing   <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      note_idx  <= '0;
      song_done <= 1'b0;
      play_note <= 8'h00;
      dur       <= '0;
      tick_cnt  <= '0;
      cyc_cnt   <= '0;
      tick_len  <= 24'd1;
    end else begin
      song_done <= 1'b0;
      if (stop) begin
        state    <= StIdle;
        note     <= 8'h00;
        playing  <= 1'b0;
        mem_req  <= 1'b0;
        mem_addr <= '0;
      end else begin
        case (state)
          StIdle: begin
            if (start) begin
              note_idx <= '0;
              tick_len <= (tick_cycles == 24'd0) ? 24'd1 : tick_cycles;
              state    <= StFetchNote;
              playing  <= 1'b1;
              mem_req  <= 1'b1;
              mem_addr <= '0;
            end
          end
          StFetchNote: begin
            if (rd_done) begin
              if (mem_rdata == 8'hFF) begin
                if (loop_en) begin
                  note_idx <= '0;
                  mem_addr <= '0;
                end else begin
                  song_done <= 1'b1;
                  note      <= 8'h00;
                  state     <= StIdle;
                  playing   <= 1'b0;
                  mem_req   <= 1'b0;
                end
              end else begin
                play_note <= mem_rdata;
                state     <= StFetchDur;
                mem_addr  <= {note_idx, 1'b1};
              end
            end
          end
          StFetchDur: begin
            if (rd_done) begin
              dur      <= (rd_dur == '0) ? DUR_W'(1) : rd_dur;
              note     <= play_note;
              tick_cnt <= '0;
              cyc_cnt  <= '0;
              mem_req  <= 1'b0;
              state    <= StPlay;
            end
          end
          StPlay: begin
            note <= pause ? 8'h00 : play_note;
            if (!pause) begin
              if (cyc_cnt == tick_len - 24'd1) begin
                cyc_cnt <= '0;
                if (tick_cnt == dur - 1'b1) begin
                  note_idx <= idx_next;
                  state    <= StFetchNote;
                  mem_req  <= 1'b1;
                  mem_addr <= {idx_next, 1'b0};
                end else begin
                  tick_cnt <= tick_cnt + 1'b1;
                end
              end else begin
                cyc_cnt <= cyc_cnt + 24'd1;
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
